// File: rtl/revaluate_inverse_dp_if.sv
// Request/result bundle for the inverse Revaluate datapath.
// The master side issues start with a full state; the slave side returns
// the recovered state plus busy/done/error status.
interface revaluate_inverse_dp_if #(
    parameter int NUM_CELLS = 1600
);
    logic                 start;
    logic [0:NUM_CELLS-1] data_in;
    logic [0:NUM_CELLS-1] data_out;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        output start,
        output data_in,
        input  data_out,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  start,
        input  data_in,
        output data_out,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/revaluate_inverse_dp.sv
// Inverse Revaluate: recovers the pre-Revaluate state by sweeping a shared
// NUM_ROW-bit candidate through every value. Each row latches the candidate
// whose forward transform equals that row's captured input bits.
// Cell (i,j,k) sits at index k*NUM_ROW*NUM_COLUMN + j*NUM_ROW + i, so row
// (j,k) occupies the NUM_ROW consecutive bits starting at (k*NUM_COLUMN+j)*NUM_ROW.
module revaluate_inverse_dp #(
    parameter int NUM_ROW    = 5,
    parameter int NUM_COLUMN = 5,
    parameter int NUM_PAGE   = 64
) (
    input logic                   clk,
    input logic                   rst,
    revaluate_inverse_dp_if.slave bus
);
    localparam int NUM_CELLS = NUM_ROW * NUM_COLUMN * NUM_PAGE;
    localparam int NUM_LINES = NUM_COLUMN * NUM_PAGE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [NUM_ROW-1:0]   cand;
    logic [0:NUM_CELLS-1] in_reg;
    logic [NUM_LINES-1:0] found;
    logic [NUM_LINES-1:0] match;
    logic [NUM_ROW-1:0]   fwd_cand;
    logic                 error_q;

    // Forward transform of one row. Rotating right by one and two positions
    // lines up c[(i+1)%N] and c[(i+2)%N] with bit i without any index math.
    function automatic logic [NUM_ROW-1:0] revaluate(input logic [NUM_ROW-1:0] c);
        logic [NUM_ROW-1:0] rot1;
        logic [NUM_ROW-1:0] rot2;
        rot1 = {c[0],   c[NUM_ROW-1:1]};
        rot2 = {c[1:0], c[NUM_ROW-1:2]};
        return c ^ (~rot1 & rot2);
    endfunction

    // The candidate is shared, so its forward image is computed once for all rows
    assign fwd_cand = revaluate(cand);

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: IDLE -> SEARCH on start, SEARCH -> FINISH after the
    // last candidate, FINISH lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SEARCH;
            SEARCH:  if (&cand)     state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Input capture, candidate sweep and the end-of-search coverage check;
    // a row still unmatched after the final candidate raises error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_reg  <= '0;
            cand    <= '0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        in_reg <= bus.data_in;
                        cand   <= '0;
                    end
                end
                SEARCH: begin
                    cand <= cand + 1'b1;
                    if (&cand) begin
                        error_q <= ~&(found | match);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- per-row compare and result registers ----
    for (genvar r = 0; r < NUM_LINES; r++) begin : g_line
        logic [NUM_ROW-1:0] line_bits;
        logic [NUM_ROW-1:0] line_out;
        logic               line_found;

        for (genvar i = 0; i < NUM_ROW; i++) begin : g_cell
            assign line_bits[i]                  = in_reg[r*NUM_ROW + i];
            assign bus.data_out[r*NUM_ROW + i]   = line_out[i];
        end

        // The found guard keeps the first matching candidate for this row
        assign match[r] = (line_bits == fwd_cand) && !line_found;
        assign found[r] = line_found;

        // Latch the candidate into this row on its first match during SEARCH;
        // rows never matched keep their previous contents
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                line_found <= 1'b0;
                line_out   <= '0;
            end else if (state_q == IDLE && bus.start) begin
                line_found <= 1'b0;
            end else if (state_q == SEARCH && match[r]) begin
                line_found <= 1'b1;
                line_out   <= cand;
            end
        end
    end

    // ---- status outputs ----
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == FINISH);
    assign bus.error = error_q;

endmodule

// File: tb/tb_revaluate_inverse_dp.sv
// Testbench for revaluate_inverse_dp: directed and randomized states are
// encoded with a forward Revaluate model and the decoded result must equal
// the original state, with the documented 33-cycle handshake.
module tb_revaluate_inverse_dp;
    localparam int NUM_ROW    = 5;
    localparam int NUM_COLUMN = 5;
    localparam int NUM_PAGE   = 64;
    localparam int NUM_CELLS  = NUM_ROW * NUM_COLUMN * NUM_PAGE;
    localparam int NUM_LINES  = NUM_COLUMN * NUM_PAGE;

    typedef logic [0:NUM_CELLS-1] state_vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    revaluate_inverse_dp_if #(.NUM_CELLS(NUM_CELLS)) bus ();

    revaluate_inverse_dp #(
        .NUM_ROW   (NUM_ROW),
        .NUM_COLUMN(NUM_COLUMN),
        .NUM_PAGE  (NUM_PAGE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Forward Revaluate applied to a whole state, straight from the row rule
    function automatic state_vec_t revaluate_model(input state_vec_t a);
        state_vec_t o;
        int base;
        o = '0;
        for (int line = 0; line < NUM_LINES; line++) begin
            base = line * NUM_ROW;
            for (int i = 0; i < NUM_ROW; i++) begin
                o[base + i] = a[base + i] ^
                              (~a[base + (i + 1) % NUM_ROW] & a[base + (i + 2) % NUM_ROW]);
            end
        end
        return o;
    endfunction

    function automatic state_vec_t random_state();
        state_vec_t s;
        logic [31:0] w;
        s = '0;
        for (int b = 0; b < NUM_CELLS; b++) begin
            if (b % 32 == 0) w = $urandom;
            s[b] = w[b % 32];
        end
        return s;
    endfunction

    // Index of the first differing cell, -1 when identical (used for messages)
    function automatic int first_diff(input state_vec_t a, input state_vec_t b);
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (a[i] !== b[i]) return i;
        end
        return -1;
    endfunction

    // One operation: start accepted at E0, then 40 samples on falling edges.
    // Sample m lies between edges Em and Em+1. Optional re-pulses of start at
    // samples repulse_a/repulse_b; optional scrambling of data_in during SEARCH.
    task automatic run_op(input state_vec_t din, input int repulse_a, input int repulse_b,
                          input bit scramble, output int done_first,
                          output int done_count, output int busy_count);
        @(negedge clk);
        bus.data_in = din;
        bus.start   = 1'b1;
        @(negedge clk);
        done_first = -1;
        done_count = 0;
        busy_count = 0;
        for (int m = 0; m < 40; m++) begin
            if (bus.done === 1'b1) begin
                done_count++;
                if (done_first < 0) done_first = m;
            end
            if (bus.busy === 1'b1) busy_count++;
            bus.start = (m == repulse_a) || (m == repulse_b);
            if (scramble && m < 32) bus.data_in = random_state();
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.data_in  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.data_out !== state_vec_t'(0)) begin
            errors++;
            $display("FAIL reset_data_out: first nonzero cell %0d", first_diff(bus.data_out, '0));
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b want 0", bus.done);
        end
        checks++;
        if (bus.error !== 1'b0) begin
            errors++; $display("FAIL reset_error: got %b want 0", bus.error);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_zero();
        int df, dc, bc;
        run_op('0, -1, -1, 1'b0, df, dc, bc);
        checks++;
        if (df !== 32) begin
            errors++; $display("FAIL zero_done_time: got %0d want 32", df);
        end
        checks++;
        if (dc !== 1) begin
            errors++; $display("FAIL zero_done_count: got %0d want 1", dc);
        end
        checks++;
        if (bc !== 33) begin
            errors++; $display("FAIL zero_busy_cycles: got %0d want 33", bc);
        end
        checks++;
        if (bus.data_out !== state_vec_t'(0)) begin
            errors++;
            $display("FAIL zero_data_out: first wrong cell %0d", first_diff(bus.data_out, '0));
        end
        checks++;
        if (bus.error !== 1'b0) begin
            errors++; $display("FAIL zero_error: got %b want 0", bus.error);
        end
    endtask

    task automatic test_all_one();
        int df, dc, bc;
        state_vec_t ones;
        ones = '1;
        run_op(ones, -1, -1, 1'b0, df, dc, bc);
        checks++;
        if (bus.data_out !== ones) begin
            errors++;
            $display("FAIL ones_data_out: first wrong cell %0d", first_diff(bus.data_out, ones));
        end
        checks++;
        if (bus.error !== 1'b0) begin
            errors++; $display("FAIL ones_error: got %b want 0", bus.error);
        end
        checks++;
        if (df !== 32) begin
            errors++; $display("FAIL ones_done_time: got %0d want 32", df);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.data_out !== ones) begin
            errors++;
            $display("FAIL ones_idle_hold: first wrong cell %0d", first_diff(bus.data_out, ones));
        end
    endtask

    task automatic test_single_row();
        int df, dc, bc;
        state_vec_t din, want;
        din     = '0;
        din[0]  = 1'b1;
        din[3]  = 1'b1;
        want    = '0;
        want[0] = 1'b1;
        run_op(din, -1, -1, 1'b0, df, dc, bc);
        checks++;
        if (bus.data_out !== want) begin
            errors++;
            $display("FAIL single_row_data_out: first wrong cell %0d got %b want %b",
                     first_diff(bus.data_out, want), bus.data_out[0:4], want[0:4]);
        end
        checks++;
        if (bus.error !== 1'b0) begin
            errors++; $display("FAIL single_row_error: got %b want 0", bus.error);
        end
    endtask

    task automatic test_random();
        int df, dc, bc;
        state_vec_t orig, enc;
        for (int n = 0; n < 50; n++) begin
            orig = random_state();
            enc  = revaluate_model(orig);
            run_op(enc, -1, -1, n[0], df, dc, bc);
            checks++;
            if (bus.data_out !== orig) begin
                errors++;
                $display("FAIL random_data_out[%0d]: first wrong cell %0d got %b want %b",
                         n, first_diff(bus.data_out, orig),
                         bus.data_out[first_diff(bus.data_out, orig)],
                         orig[first_diff(bus.data_out, orig)]);
            end
            checks++;
            if (bus.error !== 1'b0) begin
                errors++; $display("FAIL random_error[%0d]: got %b want 0", n, bus.error);
            end
            checks++;
            if (df !== 32 || dc !== 1) begin
                errors++;
                $display("FAIL random_done[%0d]: first at %0d count %0d want 32/1", n, df, dc);
            end
        end
    endtask

    task automatic test_start_ignored();
        int df, dc, bc;
        state_vec_t orig, enc;
        orig = random_state();
        enc  = revaluate_model(orig);
        run_op(enc, 5, 20, 1'b1, df, dc, bc);
        checks++;
        if (dc !== 1 || df !== 32) begin
            errors++;
            $display("FAIL busy_start_done: first at %0d count %0d want 32/1", df, dc);
        end
        checks++;
        if (bc !== 33) begin
            errors++; $display("FAIL busy_start_busy_cycles: got %0d want 33", bc);
        end
        checks++;
        if (bus.data_out !== orig) begin
            errors++;
            $display("FAIL busy_start_data_out: first wrong cell %0d", first_diff(bus.data_out, orig));
        end
        orig = random_state();
        enc  = revaluate_model(orig);
        run_op(enc, 32, -1, 1'b0, df, dc, bc);
        checks++;
        if (dc !== 1 || bc !== 33) begin
            errors++;
            $display("FAIL finish_start_ignored: done count %0d busy cycles %0d want 1/33", dc, bc);
        end
        checks++;
        if (bus.data_out !== orig) begin
            errors++;
            $display("FAIL finish_start_data_out: first wrong cell %0d", first_diff(bus.data_out, orig));
        end
    endtask

    task automatic test_reset_mid();
        int df, dc, bc;
        int early_done;
        state_vec_t orig, enc;
        orig = random_state();
        enc  = revaluate_model(orig);
        early_done = 0;
        @(negedge clk);
        bus.data_in = enc;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int m = 0; m < 12; m++) begin
            if (bus.done === 1'b1) early_done++;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== state_vec_t'(0)) begin
            errors++;
            $display("FAIL midreset_data_out: first nonzero cell %0d", first_diff(bus.data_out, '0));
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_status: busy %b error %b want 0/0", bus.busy, bus.error);
        end
        for (int m = 0; m < 25; m++) begin
            @(negedge clk);
            if (bus.done === 1'b1) early_done++;
            if (m == 2) rst = 1'b0;
        end
        checks++;
        if (early_done !== 0) begin
            errors++; $display("FAIL midreset_no_done: got %0d pulses want 0", early_done);
        end
        orig = random_state();
        enc  = revaluate_model(orig);
        run_op(enc, -1, -1, 1'b0, df, dc, bc);
        checks++;
        if (df !== 32 || dc !== 1) begin
            errors++;
            $display("FAIL after_reset_done: first at %0d count %0d want 32/1", df, dc);
        end
        checks++;
        if (bus.data_out !== orig) begin
            errors++;
            $display("FAIL after_reset_data_out: first wrong cell %0d", first_diff(bus.data_out, orig));
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_all_one();
        test_single_row();
        test_random();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
